rv32_data_mem_responder: RTL

- Responder end of the core's data-memory request interface: it accepts the memory_request_t issued by the memory stage and answers with request_done, load data and an access-fault flag.
- Holds a word-organised on-chip data RAM.
- Applies a programmable fixed access latency so pipeline stall paths can be exercised.
- Sits on the data bus between the memory stage (initiator) and the write-back stage (consumer of read_data).

---
 rtl/rv32_types.sv | 81 ++++++++
 rtl/rv32_data_mem_responder_if.sv | 24 ++
 rtl/rv32_byte_lane_ram.sv | 29 ++
 rtl/rv32_data_mem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rv32_types.sv
// Shared RV32 core types: data-memory request encoding plus the helpers used by
// the data-memory responder to decode sizes, byte lanes and load extension.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [31:0] addr;
    mem_op_t     op;
    logic [31:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } data_mem_state_t;

  function automatic logic is_load(mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] addr_lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
      MEM_LW, MEM_SW:          return addr_lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] mem_byte_enable(mem_op_t op, logic [1:0] addr_lo);
    case (op)
      MEM_SB:  return 4'b0001 << addr_lo;
      MEM_SH:  return 4'b0011 << addr_lo;
      MEM_SW:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the store value lets the byte enables alone pick the lane.
  function automatic logic [31:0] store_lanes(mem_op_t op, logic [31:0] data);
    case (op)
      MEM_SB:  return {4{data[7:0]}};
      MEM_SH:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(mem_op_t op, logic [1:0] addr_lo,
                                              logic [31:0] word);
    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane   = word >> {addr_lo, 3'b000};
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    case (op)
      MEM_LB:  return 32'(lane_b);
      MEM_LBU: return {24'h0, lane[7:0]};
      MEM_LH:  return 32'(lane_h);
      MEM_LHU: return {16'h0, lane[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/rv32_data_mem_responder_if.sv
// Data-memory bus between the memory stage (master) and the data-memory
// responder (slave).
interface rv32_data_mem_responder_if;
    import rv32_types::*;

    memory_request_t data_request;
    logic            request_done;
    logic [31:0]     read_data;
    logic            access_fault;

    modport master (
        output data_request,
        input  request_done,
        input  read_data,
        input  access_fault
    );

    modport slave (
        input  data_request,
        output request_done,
        output read_data,
        output access_fault
    );
endinterface

// File: rtl/rv32_byte_lane_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// A write cycle leaves rdata untouched so the last read result holds.
module rv32_byte_lane_ram #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/rv32_data_mem_responder.sv
// Data-memory responder: accepts one request at a time, waits a fixed latency,
// then completes it against the on-chip RAM or flags an access fault.
module rv32_data_mem_responder
    import rv32_types::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input logic                      clk,
    input logic                      resetn,
    rv32_data_mem_responder_if.slave data_bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    data_mem_state_t state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            accept;
    logic            to_done;

    memory_request_t req_l;
    memory_request_t cur;
    logic            cur_oor;
    logic            cur_fault;

    logic            ld_valid;
    mem_op_t         ld_op;
    logic [1:0]      ld_lo;

    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;

    // In IDLE the live request is the one being accepted; afterwards only the
    // latched copy matters, so initiator changes mid-access are invisible.
    always_comb begin
        cur       = (state == IDLE) ? data_bus.data_request : req_l;
        cur_oor   = ({1'b0, cur.addr} < {1'b0, BASE_ADDR}) || ({1'b0, cur.addr} >= LIMIT);
        cur_fault = cur_oor || is_misaligned(cur.op, cur.addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // WAIT covers cycles t+1 .. t+LATENCY-1; a single-cycle latency skips it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        to_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_bus.data_request.op != MEM_NOP) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                        to_done   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    to_done   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_l    <= '0;
            ld_valid <= 1'b0;
            ld_op    <= MEM_NOP;
            ld_lo    <= 2'b00;
        end else begin
            if (accept) req_l <= data_bus.data_request;
            if (to_done) begin
                if (cur_fault) begin
                    ld_valid <= 1'b0;
                end else if (is_load(cur.op)) begin
                    ld_valid <= 1'b1;
                    ld_op    <= cur.op;
                    ld_lo    <= cur.addr[1:0];
                end
            end
        end
    end

    // Loads read on entry to DONE, stores write on exit from DONE, so the
    // single RAM port is never asked for both in one cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = AW'((cur.addr - BASE_ADDR) >> 2);
        ram_wdata = store_lanes(cur.op, cur.data);
        if (resetn && !cur_fault) begin
            if (to_done && is_load(cur.op)) begin
                ram_en = 1'b1;
            end else if (state == DONE && is_store(cur.op)) begin
                ram_en = 1'b1;
                ram_we = mem_byte_enable(cur.op, cur.addr[1:0]);
            end
        end
    end

    rv32_byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign data_bus.request_done = (state == DONE);
    assign data_bus.access_fault = (state == DONE) && cur_fault;
    assign data_bus.read_data    = ld_valid ? load_extend(ld_op, ld_lo, ram_rdata) : 32'h0;

endmodule
